// File: rtl/hazard_scoreboard_if.sv
// D-stage <-> interlock scoreboard bundle: decoded source/destination info in,
// stall / bypass selects / MDU busy out.
interface hazard_scoreboard_if #(
  parameter int RW = 5,
  parameter int TW = 3,
  parameter int LW = 2
);
  logic          d_valid;
  logic [RW-1:0] d_rs;
  logic [RW-1:0] d_rt;
  logic          d_rs_en;
  logic          d_rt_en;
  logic [TW-1:0] d_rs_use;
  logic [TW-1:0] d_rt_use;
  logic          d_wr_en;
  logic [RW-1:0] d_wr_reg;
  logic [TW-1:0] d_tnew;
  logic          d_md_use;
  logic          d_md_start;
  logic          d_md_div;
  logic          flush;

  logic          stall;
  logic          md_busy;
  logic          fwd_rs;
  logic          fwd_rt;
  logic [LW-1:0] fwd_rs_sel;
  logic [LW-1:0] fwd_rt_sel;

  modport master (
    output d_valid, d_rs, d_rt, d_rs_en, d_rt_en, d_rs_use, d_rt_use,
           d_wr_en, d_wr_reg, d_tnew, d_md_use, d_md_start, d_md_div, flush,
    input  stall, md_busy, fwd_rs, fwd_rt, fwd_rs_sel, fwd_rt_sel
  );

  modport slave (
    input  d_valid, d_rs, d_rt, d_rs_en, d_rt_en, d_rs_use, d_rt_use,
           d_wr_en, d_wr_reg, d_tnew, d_md_use, d_md_start, d_md_div, flush,
    output stall, md_busy, fwd_rs, fwd_rt, fwd_rs_sel, fwd_rt_sel
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// Register scoreboard interlock for the 5-stage MIPS core: per-GPR Tnew and
// pipeline-position tracking plus an MDU occupancy counter.

// One scoreboard entry: position countdown (life) and result-readiness (tnew).
module hazard_scoreboard_entry #(
  parameter int TW    = 3,
  parameter int LW    = 2,
  parameter int DEPTH = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load_i,
  input  logic          flush_i,
  input  logic [TW-1:0] tnew_i,
  output logic [LW-1:0] life_o,
  output logic [TW-1:0] tnew_o
);
  logic [LW-1:0] life_q, life_d;
  logic [TW-1:0] tnew_q, tnew_d;

  always_comb begin
    life_d = life_q;
    tnew_d = tnew_q;
    if (flush_i) begin
      life_d = '0;
      tnew_d = '0;
    end else if (load_i) begin
      // newest writer replaces any older one still in flight
      life_d = LW'(DEPTH);
      tnew_d = tnew_i;
    end else if (life_q != '0) begin
      life_d = life_q - LW'(1);
      tnew_d = (tnew_q != '0) ? tnew_q - TW'(1) : '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      life_q <= '0;
      tnew_q <= '0;
    end else begin
      life_q <= life_d;
      tnew_q <= tnew_d;
    end
  end

  assign life_o = life_q;
  assign tnew_o = tnew_q;
endmodule

module hazard_scoreboard #(
  parameter int NREG     = 32,
  parameter int RW       = 5,
  parameter int TW       = 3,
  parameter int DEPTH    = 3,
  parameter int LW       = 2,
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC  = 10
) (
  input  logic                 clk,
  input  logic                 reset,
  hazard_scoreboard_if.slave   sb
);
  localparam int MAXC = (DIV_CYC > MULT_CYC) ? DIV_CYC : MULT_CYC;
  localparam int MDW  = $clog2(MAXC + 1);

  logic [NREG-1:0][LW-1:0] life;
  logic [NREG-1:0][TW-1:0] tnew;
  logic                    issue;
  logic                    hz_rs, hz_rt, hz_md;
  logic [LW-1:0]           rs_life, rt_life;
  logic [TW-1:0]           rs_tnew, rt_tnew;
  logic [MDW-1:0]          md_cnt_q, md_cnt_d;

  // r0 is hard-wired zero and never has a writer in flight
  assign life[0] = '0;
  assign tnew[0] = '0;

  assign issue = sb.d_valid && !sb.stall && !sb.flush;

  for (genvar g = 1; g < NREG; g++) begin : g_ent
    hazard_scoreboard_entry #(
      .TW   (TW),
      .LW   (LW),
      .DEPTH(DEPTH)
    ) u_ent (
      .clk    (clk),
      .reset  (reset),
      .load_i (issue && sb.d_wr_en && (sb.d_wr_reg == RW'(g))),
      .flush_i(sb.flush),
      .tnew_i (sb.d_tnew),
      .life_o (life[g]),
      .tnew_o (tnew[g])
    );
  end

  assign rs_life = life[sb.d_rs];
  assign rt_life = life[sb.d_rt];
  assign rs_tnew = tnew[sb.d_rs];
  assign rt_tnew = tnew[sb.d_rt];

  assign hz_rs = sb.d_rs_en && (sb.d_rs != '0) && (rs_life != '0) && (rs_tnew > sb.d_rs_use);
  assign hz_rt = sb.d_rt_en && (sb.d_rt != '0) && (rt_life != '0) && (rt_tnew > sb.d_rt_use);
  assign hz_md = sb.d_md_use && (md_cnt_q != '0);

  assign sb.stall      = sb.d_valid && (hz_rs || hz_rt || hz_md);
  assign sb.fwd_rs     = (sb.d_rs != '0) && (rs_life != '0);
  assign sb.fwd_rt     = (sb.d_rt != '0) && (rt_life != '0);
  assign sb.fwd_rs_sel = rs_life;
  assign sb.fwd_rt_sel = rt_life;

  // a launched mult/div always completes, so flush leaves the counter alone
  always_comb begin
    md_cnt_d = md_cnt_q;
    if (issue && sb.d_md_start)
      md_cnt_d = sb.d_md_div ? MDW'(DIV_CYC) : MDW'(MULT_CYC);
    else if (md_cnt_q != '0)
      md_cnt_d = md_cnt_q - MDW'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) md_cnt_q <= '0;
    else        md_cnt_q <= md_cnt_d;
  end

  assign sb.md_busy = (md_cnt_q != '0);
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: timestamp-based reference model
// compared every cycle, plus literal expectations at the key points.
module tb_hazard_scoreboard;
  localparam int NREG = 32, RW = 5, TW = 3, DEPTH = 3, LW = 2;
  localparam int MULT_CYC = 5, DIV_CYC = 10;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  hazard_scoreboard_if #(.RW(RW), .TW(TW), .LW(LW)) bus ();

  hazard_scoreboard #(
    .NREG(NREG), .RW(RW), .TW(TW), .DEPTH(DEPTH), .LW(LW),
    .MULT_CYC(MULT_CYC), .DIV_CYC(DIV_CYC)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .sb   (bus)
  );

  int checks = 0;
  int errors = 0;
  bit cmp_en = 0;

  task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", nm, got, exp, $time);
    end
  endtask

  // Reference model: each register remembers the edge its newest writer
  // issued on; position and readiness follow from elapsed edges.
  int ecnt = 0;
  bit w_vld [NREG];
  int w_edge[NREG];
  int w_t0  [NREG];
  bit md_vld = 0;
  int md_edge = 0, md_len = 0;

  task automatic m_clear();
    for (int i = 0; i < NREG; i++) w_vld[i] = 0;
    md_vld = 0;
  endtask

  function automatic int m_life(int r);
    int a;
    if (r == 0 || !w_vld[r]) return 0;
    a = ecnt - w_edge[r];
    return (a >= DEPTH) ? 0 : DEPTH - a;
  endfunction

  function automatic int m_tnew(int r);
    int t;
    t = w_t0[r] - (ecnt - w_edge[r]);
    return (t < 0) ? 0 : t;
  endfunction

  function automatic bit m_busy();
    return md_vld && ((ecnt - md_edge) < md_len);
  endfunction

  function automatic bit m_haz(bit en, int r, int use_);
    return en && m_life(r) != 0 && m_tnew(r) > use_;
  endfunction

  function automatic bit m_stall();
    return bus.d_valid && (m_haz(bus.d_rs_en, int'(bus.d_rs), int'(bus.d_rs_use)) ||
                           m_haz(bus.d_rt_en, int'(bus.d_rt), int'(bus.d_rt_use)) ||
                           (bus.d_md_use && m_busy()));
  endfunction

  always @(posedge clk) begin
    bit iss;
    if (reset) begin
      iss = bus.d_valid && !m_stall() && !bus.flush;
      ecnt++;
      if (bus.flush) for (int i = 0; i < NREG; i++) w_vld[i] = 0;
      if (iss && bus.d_wr_en && bus.d_wr_reg != 0) begin
        w_vld[bus.d_wr_reg]  = 1;
        w_edge[bus.d_wr_reg] = ecnt;
        w_t0[bus.d_wr_reg]   = int'(bus.d_tnew);
      end
      if (iss && bus.d_md_start) begin
        md_vld  = 1;
        md_edge = ecnt;
        md_len  = bus.d_md_div ? DIV_CYC : MULT_CYC;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("cyc_stall",   bus.stall,      m_stall());
      chk("cyc_md_busy", bus.md_busy,    m_busy());
      chk("cyc_fwd_rs",  bus.fwd_rs,     m_life(int'(bus.d_rs)) != 0);
      chk("cyc_rs_sel",  bus.fwd_rs_sel, m_life(int'(bus.d_rs)));
      chk("cyc_fwd_rt",  bus.fwd_rt,     m_life(int'(bus.d_rt)) != 0);
      chk("cyc_rt_sel",  bus.fwd_rt_sel, m_life(int'(bus.d_rt)));
    end
  end

  task automatic step(); @(posedge clk); #1; endtask
  task automatic mid();  @(negedge clk); endtask

  task automatic idle();
    bus.d_valid = 0; bus.d_rs = '0; bus.d_rt = '0; bus.d_rs_en = 0; bus.d_rt_en = 0;
    bus.d_rs_use = '0; bus.d_rt_use = '0; bus.d_wr_en = 0; bus.d_wr_reg = '0;
    bus.d_tnew = '0; bus.d_md_use = 0; bus.d_md_start = 0; bus.d_md_div = 0; bus.flush = 0;
  endtask

  task automatic wr(int r, int t);
    bus.d_valid = 1; bus.d_wr_en = 1; bus.d_wr_reg = RW'(r); bus.d_tnew = TW'(t);
  endtask

  task automatic rd_rs(int r, int u);
    bus.d_valid = 1; bus.d_rs_en = 1; bus.d_rs = RW'(r); bus.d_rs_use = TW'(u);
  endtask

  task automatic md_start(bit dv);
    bus.d_valid = 1; bus.d_md_use = 1; bus.d_md_start = 1; bus.d_md_div = dv;
  endtask

  // launch mult/div, then hold mflo until the unit drains
  task automatic mdu_run(bit dv, int n);
    step(); idle(); md_start(dv);
    mid(); chk("mdu_launch_stall", bus.stall, 0);
    step(); idle(); bus.d_valid = 1; bus.d_md_use = 1;
    for (int i = 0; i < n; i++) begin
      mid(); chk("mflo_stall", bus.stall, 1); chk("mflo_busy", bus.md_busy, 1);
      step();
    end
    mid(); chk("mflo_release", bus.stall, 0); chk("md_idle", bus.md_busy, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    #2 reset = 0;
    #3;
    chk("rst_stall", bus.stall, 0);
    chk("rst_md_busy", bus.md_busy, 0);
    chk("rst_fwd_rs", bus.fwd_rs, 0);
    chk("rst_fwd_rt", bus.fwd_rt, 0);
    mid(); mid();
    reset = 1;
    cmp_en = 1;

    // load-use: lw r8 (tnew 2) then addu reading r8 in E
    step(); idle(); wr(8, 2);
    mid(); chk("lu_pre", bus.stall, 0);
    step(); idle(); rd_rs(8, 1);
    mid(); chk("lu_stall", bus.stall, 1); chk("lu_sel_e", bus.fwd_rs_sel, 3);
    step();
    mid(); chk("lu_go", bus.stall, 0); chk("lu_fwd", bus.fwd_rs, 1); chk("lu_sel_m", bus.fwd_rs_sel, 2);

    // branch after ALU
    step(); idle(); wr(9, 1);
    step(); idle(); rd_rs(9, 0);
    mid(); chk("br_stall", bus.stall, 1);
    step();
    mid(); chk("br_go", bus.stall, 0); chk("br_sel", bus.fwd_rs_sel, 2);

    // r0 is never a hazard
    step(); idle(); wr(0, 1);
    step(); idle(); rd_rs(0, 0);
    mid(); chk("r0_stall", bus.stall, 0); chk("r0_fwd", bus.fwd_rs, 0);

    // rt path
    step(); idle(); wr(14, 2);
    step(); idle(); bus.d_valid = 1; bus.d_rt_en = 1; bus.d_rt = RW'(14);
    mid(); chk("rt_stall", bus.stall, 1); chk("rt_sel", bus.fwd_rt_sel, 3);
    step(); step();
    mid(); chk("rt_go", bus.stall, 0); chk("rt_sel_w", bus.fwd_rt_sel, 1);

    mdu_run(0, MULT_CYC);
    mdu_run(1, DIV_CYC);

    // second mult while busy stalls
    step(); idle(); md_start(0);
    step(); idle(); md_start(0);
    mid(); chk("mult2_stall", bus.stall, 1);
    step(); idle();
    for (int i = 0; i < MULT_CYC; i++) step();
    mid(); chk("mult2_idle", bus.md_busy, 0);

    // overwrite: second writer governs
    step(); idle(); wr(10, 2);
    step(); idle(); wr(10, 1);
    step(); idle(); rd_rs(10, 0);
    mid(); chk("ow_stall", bus.stall, 1); chk("ow_sel", bus.fwd_rs_sel, 3);
    step();
    mid(); chk("ow_go", bus.stall, 0); chk("ow_sel2", bus.fwd_rs_sel, 2);

    // flush with a mult in progress
    step(); idle(); md_start(0);
    step(); idle(); wr(11, 2);
    step(); idle(); wr(12, 2); bus.flush = 1; bus.d_rs = RW'(11); bus.d_rt = RW'(12);
    mid(); chk("fl_pre_fwd", bus.fwd_rs, 1); chk("fl_pre_sel", bus.fwd_rs_sel, 3);
    step(); idle(); bus.d_rs = RW'(11); bus.d_rt = RW'(12);
    mid(); chk("fl_rs", bus.fwd_rs, 0); chk("fl_rt", bus.fwd_rt, 0); chk("fl_busy", bus.md_busy, 1);
    step(); idle();
    for (int i = 0; i < MULT_CYC; i++) step();

    // async reset while a divide is at count 6
    idle(); md_start(1);
    step(); idle();
    step(); step();
    step(); wr(13, 2);
    step(); idle(); rd_rs(13, 0); bus.d_md_use = 1;
    #1; chk("ar_busy_pre", bus.md_busy, 1); chk("ar_stall_pre", bus.stall, 1);
    #1; reset = 0; m_clear();
    #1; chk("ar_busy", bus.md_busy, 0); chk("ar_fwd", bus.fwd_rs, 0); chk("ar_stall", bus.stall, 0);
    @(posedge clk); #3 reset = 1;
    mid(); chk("ar_post_stall", bus.stall, 0);
    step(); idle();
    mid(); chk("ar_post_busy", bus.md_busy, 0);

    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised pipeline interlock for the five-stage MIPS core. It replaces fixed per-stage instruction decoding with a per-register scoreboard holding, for each in-flight destination, a Tnew countdown and a pipeline-position counter. It also tracks the multi-cycle multiply/divide unit with its own latency counter. The block sits beside the D stage. It produces the D-stage stall, the bypass-source selects for rs/rt, and the MDU busy flag.

## Interface
Parameters:
- NREG, 32, number of architectural registers; register 0 is hard-wired zero
- RW, 5, register index width (log2 NREG)
- TW, 3, width of Tnew/Tuse fields
- DEPTH, 3, stages from E entry to register-file commit (E=3, M=2, W=1)
- LW, 2, width of position counter; must satisfy DEPTH < 2^LW
- MULT_CYC, 5, mult/multu occupancy in cycles
- DIV_CYC, 10, div/divu occupancy in cycles

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low; clears all state
- d_valid  in  1  D stage holds a real instruction
- d_rs, d_rt  in  RW  source register indices
- d_rs_en, d_rt_en  in  1  source actually read
- d_rs_use, d_rt_use  in  TW  Tuse of each source (0 = needed in D, 1 = needed in E, ...)
- d_wr_en  in  1  instruction writes a GPR
- d_wr_reg  in  RW  destination index
- d_tnew  in  TW  Tnew of the result at E entry
- d_md_use  in  1  instruction touches HI/LO or the MDU (mult*, div*, mfhi, mflo, mthi, mtlo)
- d_md_start  in  1  instruction launches a mult/div; implies d_md_use
- d_md_div  in  1  with d_md_start: 1 = divide latency, 0 = multiply latency
- flush  in  1  synchronous squash of all in-flight GPR writers
- stall  out  1  freeze PC/IF-ID and inject bubble into E (combinational)
- md_busy  out  1  MDU counter non-zero (registered)
- fwd_rs, fwd_rt  out  1  the source's newest writer is still in flight; take the bypass, not the register file
- fwd_rs_sel, fwd_rt_sel  out  LW  position of that writer (3 = E, 2 = M, 1 = W)

## Operation
- Per-register state: life[r] (LW bits, 0 = no writer in flight) and tnew[r] (TW bits). Entry 0 is never written and always reads 0.
- Issue: issue = d_valid && !stall && !flush.
  - On issue with d_wr_en and d_wr_reg != 0, that entry loads life = DEPTH and tnew = d_tnew. This overrides any older writer to the same register, since the newest writer governs RAW.
- Ageing: every other entry with life != 0 decrements life by 1 and tnew by 1, saturating at 0. When life reaches 0, the entry is retired.
- Source hazard on rs: d_rs_en && d_rs != 0 && life[d_rs] != 0 && tnew[d_rs] > d_rs_use. The rt hazard is identical.
- MDU: md_cnt counter. On issue with d_md_start, it loads DIV_CYC if d_md_div, else MULT_CYC. It then decrements to 0. md_busy = (md_cnt != 0).
- MDU hazard: d_md_use && md_busy. A back-to-back MDU pair is covered because the counter is already loaded on the first one's issue edge.
- stall = d_valid && (rs hazard || rt hazard || MDU hazard).
- Bypass outputs:
  - fwd_rs = d_rs != 0 && life[d_rs] != 0; fwd_rs_sel = life[d_rs]. Same for rt.
  - These are valid regardless of d_valid and stall.
- flush: all life/tnew entries clear at the edge, and no issue occurs that cycle. md_cnt is unaffected, because a launched mult/div completes.

## Timing
- Reset values: all life, tnew and md_cnt are 0; md_busy = 0, fwd_* = 0, stall = 0. Reset clears immediately when asserted, independent of clk, including mid-MDU operation.
- stall, fwd_* and fwd_*_sel are combinational from the inputs and current state, within the same cycle.
- A writer issued at edge k is visible from cycle k+1 with life = DEPTH. It retires after DEPTH cycles.
- A stalled D instruction does not issue; scoreboard ageing continues.
- MDU occupancy: an instruction issued at edge k sets md_busy high for exactly MULT_CYC (or DIV_CYC) cycles, k+1 through k+N.

## Test plan
- Load-use: lw r8 issued (d_tnew=2), then addu reading r8 (rs_use=1) -> stall=1 for exactly 1 cycle; the next cycle gives stall=0, fwd_rs=1, fwd_rs_sel=2.
- Branch after ALU: addu r9 (d_tnew=1), then beq reading r9 (rs_use=0) -> 1-cycle stall, then fwd_rs_sel=2. With d_rs=0 and the same pattern on r0 -> stall=0, fwd_rs=0.
- MDU: mult issued, mflo next cycle -> stall held for 5 cycles, md_busy low after the 5th. The same with div gives 10 cycles. A second mult while busy also stalls.
- Overwrite: r10 written with tnew=2, then r10 written again with tnew=1 in the next cycle -> life/tnew reflect the second writer. A reader with rs_use=0 stalls 1 cycle, not 2.
- flush: with r11 in flight (life=3), assert flush together with a d_valid writer -> next cycle fwd for r11 = 0, the writer is not recorded, and md_busy is unchanged.
- Async reset during div: drive reset low at md_cnt=6 -> md_busy=0 and all fwd=0 before the next clk edge. After release, no stall until a new issue.
